// File: rtl/alu_resp_checker.sv
// alu_resp_checker
//   Response-side checker for the ALU datapath (and/xor/add/sub). Consumes
//   {op, a, b, ans} vectors, recomputes the expected result, compares, and
//   keeps pass/fail statistics plus a sticky record of the first mismatch.
//   Pipeline: S1 captures the vector and its expected value on accept;
//   S2 compares on the next edge and updates the statistics.
//
//   Optional feature macro: ALU_CHK_FLAGS_EN
//     defined   -> extra inputs zf/sf/of are checked along with ans, and
//                  output first_fail_flags {zf,sf,of} holds the expected
//                  flags of the first mismatch.
//     undefined -> only ans is compared; no flag ports.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, stop       session control pulses (start wins over stop)
//   in_valid/in_ready vector handshake
//   op, a, b, ans     vector: 0=add(b+a) 1=sub(b-a) 2=and 3=xor, result under test
//   busy, done        RUN/DRAIN, DONE state decode
//   err_pulse         one-cycle pulse per mismatch
//   mismatch          sticky mismatch flag for the session
//   pass_cnt/fail_cnt saturating match/mismatch counters
//   first_fail_idx    accept-order index of the first mismatch
//   first_fail_exp    expected value of the first mismatch
module alu_resp_checker #(
    parameter int W       = 32,
    parameter int CNT_W   = 16,
    parameter int MAX_VEC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     ans,
`ifdef ALU_CHK_FLAGS_EN
    input  logic             zf,
    input  logic             sf,
    input  logic             of,
    output logic [2:0]       first_fail_flags,
`endif
    output logic             busy,
    output logic             done,
    output logic             err_pulse,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [W-1:0]     first_fail_exp
);

    localparam int AW = $clog2(MAX_VEC + 1);
    localparam logic [AW-1:0] MAXV = AW'(MAX_VEC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    accepted;   // vectors accepted this session, stops at MAX_VEC
    logic [CNT_W-1:0] idx;        // accept-order index, wraps
    logic [2:1]       vld_pipe;   // [1]=S1 holds a vector, [2]=S2 updated last edge

    logic [W-1:0]     s1_ans;
    logic [W-1:0]     s1_exp;
    logic [CNT_W-1:0] s1_idx;
    logic [W-1:0]     exp_val;
    logic             accept;
    logic             last_vec;
    logic             s1_match;

    always_comb begin
        exp_val = '0;
        case (op)
            2'd0:    exp_val = b + a;
            2'd1:    exp_val = b - a;
            2'd2:    exp_val = a & b;
            default: exp_val = a ^ b;
        endcase
    end

`ifdef ALU_CHK_FLAGS_EN
    logic [2:0] exp_flags;
    logic [2:0] s1_flags;
    logic [2:0] s1_expf;
    logic       ovf;

    always_comb begin
        ovf = 1'b0;
        case (op)
            2'd0:    ovf = (a[W-1] == b[W-1]) && (exp_val[W-1] != a[W-1]);
            2'd1:    ovf = (a[W-1] != b[W-1]) && (exp_val[W-1] != b[W-1]);
            default: ovf = 1'b0;
        endcase
        exp_flags = {(exp_val == '0), exp_val[W-1], ovf};
    end

    assign s1_match = (s1_ans == s1_exp) && (s1_flags == s1_expf);
`else
    assign s1_match = (s1_ans == s1_exp);
`endif

    assign in_ready = (state == RUN) && (accepted < MAXV);
    assign accept   = in_valid && in_ready;
    // this accept fills the session quota
    assign last_vec = accept && ((accepted + AW'(1)) == MAXV);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            accepted       <= '0;
            idx            <= '0;
            vld_pipe       <= '0;
            s1_ans         <= '0;
            s1_exp         <= '0;
            s1_idx         <= '0;
            err_pulse      <= 1'b0;
            mismatch       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
`ifdef ALU_CHK_FLAGS_EN
            s1_flags         <= '0;
            s1_expf          <= '0;
            first_fail_flags <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
            if (start) begin
                // new session: anything in flight is discarded
                state          <= RUN;
                accepted       <= '0;
                idx            <= '0;
                vld_pipe       <= '0;
                mismatch       <= 1'b0;
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                first_fail_idx <= '0;
                first_fail_exp <= '0;
`ifdef ALU_CHK_FLAGS_EN
                first_fail_flags <= '0;
`endif
            end else begin
                case (state)
                    RUN:     if (stop || last_vec) state <= DRAIN;
                    DRAIN:   if (vld_pipe == '0) state <= DONE;
                    default: state <= state;
                endcase

                vld_pipe <= {vld_pipe[1], accept};

                if (accept) begin
                    s1_ans   <= ans;
                    s1_exp   <= exp_val;
                    s1_idx   <= idx;
                    idx      <= idx + CNT_W'(1);
                    accepted <= accepted + AW'(1);
`ifdef ALU_CHK_FLAGS_EN
                    s1_flags <= {zf, sf, of};
                    s1_expf  <= exp_flags;
`endif
                end

                if (vld_pipe[1]) begin
                    if (s1_match) begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                        err_pulse <= 1'b1;
                        if (!mismatch) begin
                            mismatch       <= 1'b1;
                            first_fail_idx <= s1_idx;
                            first_fail_exp <= s1_exp;
`ifdef ALU_CHK_FLAGS_EN
                            first_fail_flags <= s1_expf;
`endif
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_resp_checker.sv
module tb_alu_resp_checker;

    logic        clk = 1'b0;
    logic        rst, start, stop, in_valid, start4, in_valid4;
    logic [1:0]  op;
    logic [31:0] a, b, ans;

    logic        in_ready, busy, done, err_pulse, mm;
    logic [15:0] pc, fc, fidx;
    logic [31:0] fexp;
    logic        in_ready4, busy4, done4, err4, mm4;
    logic [15:0] pc4, fc4, fidx4;
    logic [31:0] fexp4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef ALU_CHK_FLAGS_EN
    logic       zf, sf, of;
    logic [2:0] fff, fff4;

    function automatic logic [2:0] tbflags(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        logic [31:0] e;
        logic v;
        e = (o == 2'd0) ? y + x : (o == 2'd1) ? y - x : (o == 2'd2) ? (x & y) : (x ^ y);
        v = (o == 2'd0) ? ((x[31] == y[31]) && (e[31] != x[31])) :
            (o == 2'd1) ? ((x[31] != y[31]) && (e[31] != y[31])) : 1'b0;
        return {(e == 32'd0), e[31], v};
    endfunction

    assign {zf, sf, of} = tbflags(op, a, b);
`endif

    alu_resp_checker dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .ans(ans),
`ifdef ALU_CHK_FLAGS_EN
        .zf(zf), .sf(sf), .of(of), .first_fail_flags(fff),
`endif
        .busy(busy), .done(done), .err_pulse(err_pulse), .mismatch(mm),
        .pass_cnt(pc), .fail_cnt(fc), .first_fail_idx(fidx), .first_fail_exp(fexp)
    );

    alu_resp_checker #(.MAX_VEC(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .stop(1'b0),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op), .a(a), .b(b), .ans(ans),
`ifdef ALU_CHK_FLAGS_EN
        .zf(zf), .sf(sf), .of(of), .first_fail_flags(fff4),
`endif
        .busy(busy4), .done(done4), .err_pulse(err4), .mismatch(mm4),
        .pass_cnt(pc4), .fail_cnt(fc4), .first_fail_idx(fidx4), .first_fail_exp(fexp4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r);
        op = o; a = x; b = y; ans = r;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, ans;
        logic        err, mm;
        logic [15:0] pc, fc, fidx;
        logic [31:0] fexp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n;
        int acc;

        tbl[0] = '{2'd2, 32'hB,        32'h4,        32'h0,        1'b0, 1'b0, 16'd1, 16'd0, 16'd0, 32'd0};
        tbl[1] = '{2'd2, 32'hB,        32'hC,        32'h8,        1'b0, 1'b0, 16'd2, 16'd0, 16'd0, 32'd0};
        tbl[2] = '{2'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 16'd3, 16'd0, 16'd0, 32'd0};
        tbl[3] = '{2'd3, 32'h9,        32'h9,        32'h1,        1'b1, 1'b1, 16'd3, 16'd1, 16'd3, 32'd0};
        tbl[4] = '{2'd1, 32'hFFFFFFFE, 32'hD,        32'hF,        1'b0, 1'b1, 16'd4, 16'd1, 16'd3, 32'd0};
        tbl[5] = '{2'd0, 32'h5,        32'h6,        32'h0,        1'b1, 1'b1, 16'd4, 16'd2, 16'd3, 32'd0};
        tbl[6] = '{2'd1, 32'h1,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b1, 16'd5, 16'd2, 16'd3, 32'd0};
        tbl[7] = '{2'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b1, 16'd6, 16'd2, 16'd3, 32'd0};
        tbl[8] = '{2'd1, 32'h3,        32'hA,        32'h6,        1'b1, 1'b1, 16'd6, 16'd3, 16'd3, 32'd0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        start4 = 1'b0; in_valid4 = 1'b0;
        drive(2'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_mismatch", mm, 0);
        chk("rst_pass", pc, 0);
        chk("rst_fail", fc, 0);
        chk("rst_fidx", fidx, 0);
        chk("rst_fexp", fexp, 0);
        rst = 1'b0;

        // session start
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_done", done, 0);

        // one vector at a time, statistics checked after the compare edge
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ans);
            in_valid = 1'b1;
            @(negedge clk); in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_err", i),   err_pulse, tbl[i].err);
            chk($sformatf("v%0d_mm", i),    mm,        tbl[i].mm);
            chk($sformatf("v%0d_pass", i),  pc,        tbl[i].pc);
            chk($sformatf("v%0d_fail", i),  fc,        tbl[i].fc);
            chk($sformatf("v%0d_fidx", i),  fidx,      tbl[i].fidx);
            chk($sformatf("v%0d_fexp", i),  fexp,      tbl[i].fexp);
        end
        @(negedge clk);
        chk("err_pulse_drops", err_pulse, 0);

        // back-to-back: three passing vectors on three consecutive cycles
        drive(2'd0, 32'h1, 32'h2, 32'h3); in_valid = 1'b1;
        @(negedge clk); chk("b2b_ready1", in_ready, 1);
        drive(2'd2, 32'hFF, 32'hF0, 32'hF0);
        @(negedge clk); chk("b2b_ready2", in_ready, 1);
        drive(2'd3, 32'h1, 32'h3, 32'h2);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_pass", pc, 9);
        chk("b2b_fail", fc, 3);

        // stop -> DRAIN -> DONE
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_in_ready", in_ready, 0);
        n = 0;
        while (!done && n < 8) begin @(negedge clk); n++; end
        chk("drain_done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_pass", pc, 9);
        chk("done_fail", fc, 3);
        chk("done_fidx", fidx, 3);

        // stop outside RUN is ignored
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        @(negedge clk);
        chk("stop_in_done", done, 1);

        // restart clears statistics
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        chk("restart_pass", pc, 0);
        chk("restart_fail", fc, 0);
        chk("restart_mm", mm, 0);
        chk("restart_fexp", fexp, 0);

        // five vectors (index 1 bad, expected 0xB), then reset mid-session
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive(2'd0, 32'h5, 32'h6, 32'h0);
            else        drive(2'd0, 32'h1, 32'h1, 32'h2);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("s2_pass", pc, 4);
        chk("s2_fail", fc, 1);
        chk("s2_fidx", fidx, 1);
        chk("s2_fexp", fexp, 32'hB);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mm", mm, 0);
        chk("midrst_pass", pc, 0);
        chk("midrst_fail", fc, 0);
        chk("midrst_fidx", fidx, 0);
        chk("midrst_fexp", fexp, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, in_ready}, 0);

        // MAX_VEC=4 session with in_valid held high
        start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        drive(2'd0, 32'h1, 32'h1, 32'h2);
        in_valid4 = 1'b1;
        acc = 0;
        n = 0;
        while (!done4 && n < 30) begin
            if (in_ready4) acc++;
            @(negedge clk);
            n++;
        end
        chk("max_accepts", acc, 4);
        chk("max_done", done4, 1);
        chk("max_in_ready", in_ready4, 0);
        chk("max_pass", pc4, 4);
        chk("max_fail", fc4, 0);
        in_valid4 = 1'b0;
        start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        chk("max_restart_pass", pc4, 0);
        chk("max_restart_done", done4, 0);
        chk("max_restart_ready", in_ready4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
